// File: rtl/and_gate_pkg.sv
// Shared limits for the and_gate_pipe family of blocks.
package and_gate_pkg;

  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MAX = 4;

endpackage : and_gate_pkg

// File: rtl/and_gate_stage.sv
// One valid-qualified pipeline register: data loads only with a valid word,
// valid shifts every cycle, both clear asynchronously on reset.
module and_gate_stage
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      // Holding data on bubbles keeps the last result visible and blocks X inputs
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule : and_gate_stage

// File: rtl/and_gate_pipe.sv
// Registered bitwise AND with a valid-qualified pipeline of STAGES registers,
// an unregistered a & b tap and reduction flags over the registered result.
module and_gate_pipe
  import and_gate_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_comb,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic             y_any
);

  generate
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("and_gate_pipe: WIDTH %0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end
    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("and_gate_pipe: STAGES %0d outside 1..%0d", STAGES, STAGES_MAX);
    end
  endgenerate

  // Index 0 is the combinational input side; index STAGES is the output stage
  logic [STAGES:0][WIDTH-1:0] stage_data;
  logic [STAGES:0]            stage_valid;

  assign stage_data[0]  = a & b;
  assign stage_valid[0] = in_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    and_gate_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (stage_valid[i]),
      .in_data   (stage_data[i]),
      .out_valid (stage_valid[i+1]),
      .out_data  (stage_data[i+1])
    );
  end

  assign y_comb    = stage_data[0];
  assign y         = stage_data[STAGES];
  assign out_valid = stage_valid[STAGES];
  assign y_all     = &y;
  assign y_any     = |y;

endmodule : and_gate_pipe

// File: tb/tb_and_gate_pipe.sv
// Self-checking bench for and_gate_pipe: four instances at different
// WIDTH/STAGES settings share one clock and reset.
module tb_and_gate_pipe;

  localparam int S2 = 2;

  logic clk;
  logic rst_n;

  // u1: WIDTH=1, STAGES=1
  logic       v1, ov1, ya1, yn1;
  logic [0:0] a1, b1, yc1, y1;
  // u3: WIDTH=8, STAGES=3
  logic       v3, ov3, ya3, yn3;
  logic [7:0] a3, b3, yc3, y3;
  // u4: WIDTH=4, STAGES=4
  logic       v4, ov4, ya4, yn4;
  logic [3:0] a4, b4, yc4, y4;
  // u2: WIDTH=16, STAGES=2
  logic        v2, ov2, ya2, yn2;
  logic [15:0] a2, b2, yc2, y2;

  int errors;
  int checks;

  and_gate_pipe #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .y_comb(yc1), .out_valid(ov1), .y(y1), .y_all(ya1), .y_any(yn1));

  and_gate_pipe #(.WIDTH(8), .STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .a(a3), .b(b3),
    .y_comb(yc3), .out_valid(ov3), .y(y3), .y_all(ya3), .y_any(yn3));

  and_gate_pipe #(.WIDTH(4), .STAGES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
    .y_comb(yc4), .out_valid(ov4), .y(y4), .y_all(ya4), .y_any(yn4));

  and_gate_pipe #(.WIDTH(16), .STAGES(S2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2),
    .y_comb(yc2), .out_valid(ov2), .y(y2), .y_all(ya2), .y_any(yn2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs of every instance must be zero while reset is held
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (y1 !== 1'b0 || ov1 !== 1'b0 || ya1 !== 1'b0 || yn1 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_u1: y=%b ov=%b all=%b any=%b expected 0 0 0 0", y1, ov1, ya1, yn1); end
    checks++; if (y3 !== 8'h00 || ov3 !== 1'b0 || ya3 !== 1'b0 || yn3 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_u3: y=%h ov=%b all=%b any=%b expected 00 0 0 0", y3, ov3, ya3, yn3); end
    checks++; if (y4 !== 4'h0 || ov4 !== 1'b0 || ya4 !== 1'b0 || yn4 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_u4: y=%h ov=%b all=%b any=%b expected 0 0 0 0", y4, ov4, ya4, yn4); end
    checks++; if (y2 !== 16'h0 || ov2 !== 1'b0 || ya2 !== 1'b0 || yn2 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_u2: y=%h ov=%b all=%b any=%b expected 0 0 0 0", y2, ov2, ya2, yn2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Exhaustive two-input truth table on the single-lane, single-stage instance
  task automatic test_truth_table();
    logic exp;
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i & 1);
      v1 = 1'b1;
      exp = (i == 3);
      #1;
      checks++; if (yc1 !== exp) begin
        errors++; $display("[TB] FAIL truth_comb_%0d: got %b expected %b", i, yc1, exp); end
      @(negedge clk);
      checks++; if (y1 !== exp || ov1 !== 1'b1 || ya1 !== exp || yn1 !== exp) begin
        errors++; $display("[TB] FAIL truth_reg_%0d: y=%b ov=%b all=%b any=%b expected %b 1 %b %b",
                           i, y1, ov1, ya1, yn1, exp, exp, exp); end
    end
  endtask

  // Asynchronous reset between edges clears the registered side only
  task automatic test_async_reset();
    int budget;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    budget = 0;
    while (y1 !== 1'b1 && budget < 5) begin
      @(negedge clk);
      budget++;
    end
    checks++; if (y1 !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_wait: y=%b expected 1 within 5 cycles", y1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (y1 !== 1'b0 || ov1 !== 1'b0 || ya1 !== 1'b0 || yn1 !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: y=%b ov=%b all=%b any=%b expected 0 0 0 0", y1, ov1, ya1, yn1); end
    checks++; if (yc1 !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_comb: got %b expected 1", yc1); end
    v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // word, bubble, word through three stages
  task automatic test_latency_bubbles();
    logic [7:0] exp_y  [5] = '{8'h00, 8'h00, 8'h30, 8'h30, 8'hFF};
    logic       exp_ov [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int e = 0; e < 5; e++) begin
      case (e)
        0:       begin a3 = 8'hF0; b3 = 8'h3C; v3 = 1'b1; end
        2:       begin a3 = 8'hFF; b3 = 8'hFF; v3 = 1'b1; end
        default: begin a3 = 8'($urandom); b3 = 8'($urandom); v3 = 1'b0; end
      endcase
      @(negedge clk);
      checks++; if (y3 !== exp_y[e] || ov3 !== exp_ov[e]) begin
        errors++; $display("[TB] FAIL latency_e%0d: y=%h ov=%b expected %h %b", e + 1, y3, ov3, exp_y[e], exp_ov[e]); end
    end
    checks++; if (ya3 !== 1'b1 || yn3 !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_flags: all=%b any=%b expected 1 1", ya3, yn3); end
    v3 = 1'b0;
  endtask

  // Launch 0xA, then idle with a=b=0xF and finally X operands; result must hold
  task automatic test_hold();
    logic [3:0] exp_y;
    logic       exp_ov;
    a4 = 4'hA; b4 = 4'hF; v4 = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      v4 = 1'b0;
      if (e < 9) begin a4 = 4'hF; b4 = 4'hF; end
      else       begin a4 = 4'bxxxx; b4 = 4'hF; end
      exp_y  = (e >= 4) ? 4'hA : 4'h0;
      exp_ov = (e == 4);
      checks++; if (y4 !== exp_y || ov4 !== exp_ov) begin
        errors++; $display("[TB] FAIL hold_e%0d: y=%h ov=%b expected %h %b", e, y4, ov4, exp_y, exp_ov); end
    end
    checks++; if (ya4 !== 1'b0 || yn4 !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_flags: all=%b any=%b expected 0 1", ya4, yn4); end
    a4 = 4'h0; b4 = 4'h0;
  endtask

  // Three words in flight when reset hits must never surface
  task automatic test_reset_mid();
    for (int e = 0; e < 3; e++) begin
      a4 = 4'($urandom) | 4'h1; b4 = 4'hF; v4 = 1'b1;
      @(negedge clk);
    end
    v4 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      checks++; if (ov4 !== 1'b0 || y4 !== 4'h0) begin
        errors++; $display("[TB] FAIL reset_mid_c%0d: ov=%b y=%h expected 0 0", e, ov4, y4); end
      @(negedge clk);
    end
  endtask

  // Random traffic against a scoreboard of launched words
  task automatic test_random();
    bit          hist_v [$];
    logic [15:0] hist_d [$];
    logic [15:0] last_y;
    logic        exp_v;
    int          k;
    v2 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_y = 16'h0;
    for (int n = 0; n < 1000; n++) begin
      v2 = ($urandom_range(0, 3) != 0);
      a2 = 16'($urandom);
      b2 = 16'($urandom);
      #1;
      checks++; if (yc2 !== (a2 & b2)) begin
        errors++; $display("[TB] FAIL rand_comb_%0d: got %h expected %h", n, yc2, a2 & b2); end
      hist_v.push_back(v2);
      hist_d.push_back(a2 & b2);
      @(negedge clk);
      k = n - S2 + 1;
      exp_v = 1'b0;
      if (k >= 0) begin
        exp_v = hist_v[k];
        if (exp_v) last_y = hist_d[k];
      end
      checks++; if (y2 !== last_y || ov2 !== exp_v || ya2 !== (last_y == 16'hFFFF) || yn2 !== (last_y != 16'h0)) begin
        errors++; $display("[TB] FAIL rand_out_%0d: y=%h ov=%b all=%b any=%b expected %h %b %b %b",
                           n, y2, ov2, ya2, yn2, last_y, exp_v, last_y == 16'hFFFF, last_y != 16'h0); end
    end
    v2 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0;
    v3 = 1'b0; a3 = '0; b3 = '0;
    v4 = 1'b0; a4 = '0; b4 = '0;
    v2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_truth_table();
    test_async_reset();
    test_latency_bubbles();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_and_gate_pipe
